// File: rtl/tl_pkg.sv
// Shared types for the traffic-light controller: phase codes, lamp encodings
// {R,G,Y} and the decoded mode/delay reply of the decision block.
package tl_pkg;

    typedef enum logic [1:0] {
        MAIN_G = 2'b00,
        MAIN_Y = 2'b01,
        SIDE_G = 2'b10,
        SIDE_Y = 2'b11
    } phase_e;

    typedef logic [2:0] rgy_t;

    localparam rgy_t LAMP_R = 3'b100;
    localparam rgy_t LAMP_G = 3'b010;
    localparam rgy_t LAMP_Y = 3'b001;

    typedef struct packed {
        rgy_t main_rgy;
        rgy_t side_rgy;
    } lamps_t;

    typedef enum logic [1:0] {
        DEC_HOLD    = 2'b00,
        DEC_EXTEND  = 2'b01,
        DEC_ADVANCE = 2'b10
    } decision_e;

    // Advance dominates; delay only matters when advance is not requested.
    function automatic decision_e decode_decision(input logic mode, input logic delay);
        if (mode)
            return DEC_ADVANCE;
        else if (delay)
            return DEC_EXTEND;
        else
            return DEC_HOLD;
    endfunction

    function automatic lamps_t phase_lamps(input phase_e phase);
        lamps_t l;
        case (phase)
            MAIN_G:  l = '{main_rgy: LAMP_G, side_rgy: LAMP_R};
            MAIN_Y:  l = '{main_rgy: LAMP_Y, side_rgy: LAMP_R};
            SIDE_G:  l = '{main_rgy: LAMP_R, side_rgy: LAMP_G};
            default: l = '{main_rgy: LAMP_R, side_rgy: LAMP_Y};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Free-running prescaler: tick_o is high for the one clk in which the
// prescaler sits at CLK_DIV-1.
module tl_tick_gen #(
    parameter int CLK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else if (presc_q == LAST)
            presc_q <= '0;
        else
            presc_q <= presc_q + 1'b1;
    end

    assign tick_o = (presc_q == LAST);

endmodule

// File: rtl/tl_phase_seq.sv
// Phase sequencer/timer: phase FSM, phase timer, car-sensor sync/latch and lamp
// decode. Optional flashing-yellow mode is compiled in with TL_FLASH_EN.
module tl_phase_seq
    import tl_pkg::*;
#(
    parameter int CLK_DIV  = 50_000,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 3,
    parameter int T_EXT    = 5,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_i,
    input  logic       mode_i,
    input  logic       delay_i,
`ifdef TL_FLASH_EN
    input  logic       flash_i,
`endif
    output logic [1:0] state_o,
    output logic       full_o,
    output logic       c_o,
    output logic [2:0] main_rgy_o,
    output logic [2:0] side_rgy_o
);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(T_EXT - 1);

    logic             tick;
    phase_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_last;
    logic             ext_q, ext_d;
    logic             full_q, full_d;
    logic             full_seen_q;
    logic             c_q, c_d;
    logic [1:0]       car_sync_q;
    decision_e        decision;
    lamps_t           lamps;
`ifdef TL_FLASH_EN
    logic             flash_q;
    logic             flash_y_q, flash_y_d;
`endif

    tl_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MAIN_G;
            count_q     <= '0;
            ext_q       <= 1'b0;
            full_q      <= 1'b0;
            full_seen_q <= 1'b0;
            c_q         <= 1'b0;
            car_sync_q  <= 2'b00;
`ifdef TL_FLASH_EN
            flash_q     <= 1'b0;
            flash_y_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ext_q       <= ext_d;
            full_q      <= full_d;
            full_seen_q <= full_q;
            c_q         <= c_d;
            car_sync_q  <= {car_sync_q[0], car_i};
`ifdef TL_FLASH_EN
            flash_q     <= flash_i;
            flash_y_q   <= flash_y_d;
`endif
        end
    end

    // A decision is only trusted once full_o has been visible for a full
    // cycle, because the upstream reply is registered one clk behind us.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ext_d      = ext_q;
        full_d     = full_q;
        c_d        = c_q | car_sync_q[1];
        decision   = decode_decision(mode_i, delay_i);
        count_last = ext_q ? E_LAST
                   : ((state_q == MAIN_Y || state_q == SIDE_Y) ? Y_LAST : G_LAST);

        if (full_q && full_seen_q) begin
            case (decision)
                DEC_ADVANCE: begin
                    state_d = phase_e'(state_q + 2'd1);
                    count_d = '0;
                    ext_d   = 1'b0;
                    full_d  = 1'b0;
                    if (state_q == MAIN_Y)
                        c_d = 1'b0;
                end
                DEC_EXTEND: begin
                    count_d = '0;
                    ext_d   = 1'b1;
                    full_d  = 1'b0;
                end
                default: ;
            endcase
        end else if (!full_q && tick) begin
            if (count_q == count_last)
                full_d = 1'b1;
            else
                count_d = count_q + 1'b1;
        end

`ifdef TL_FLASH_EN
        flash_y_d = flash_y_q;
        if (flash_i) begin
            state_d   = state_q;
            count_d   = count_q;
            ext_d     = ext_q;
            full_d    = 1'b0;
            c_d       = c_q | car_sync_q[1];
            flash_y_d = !flash_q ? 1'b1 : (tick ? ~flash_y_q : flash_y_q);
        end else if (flash_q) begin
            state_d = MAIN_Y;
            count_d = '0;
            ext_d   = 1'b0;
            full_d  = 1'b0;
        end
`endif
    end

    always_comb begin
        lamps = phase_lamps(state_q);
`ifdef TL_FLASH_EN
        if (flash_q) begin
            lamps.main_rgy = flash_y_q ? LAMP_Y : 3'b000;
            lamps.side_rgy = flash_y_q ? LAMP_Y : 3'b000;
        end
`endif
    end

    assign state_o    = state_q;
    assign full_o     = full_q;
    assign c_o        = c_q;
    assign main_rgy_o = lamps.main_rgy;
    assign side_rgy_o = lamps.side_rgy;

endmodule
